csr_regfile: RTL

//  Machine-mode CSR storage: the write-side consumer of the execute stage's CSR result
//  (csr_exe_result/csr_exe_valid) and the source of the CSR read data it consumes.

---
 rtl/csr_regfile.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/csr_regfile.sv
// Machine-mode CSR file: mstatus/misa/mtvec/mscratch/mepc/mcause/mcycle/minstret/mhartid.
// Define CSR_BYPASS_EN to forward a same-cycle write onto the combinational read port.
module csr_regfile #(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] MISA_VAL = 64'h8000_0000_0014_1101,
  parameter logic [XLEN-1:0] HART_ID  = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [11:0]     csr_raddr_i,
  output logic [XLEN-1:0] csr_rdata_o,
  output logic            csr_illegal_o,
  input  logic            csr_wen_i,
  input  logic [11:0]     csr_waddr_i,
  input  logic [XLEN-1:0] csr_wdata_i,
  input  logic            trap_valid_i,
  input  logic [XLEN-1:0] trap_cause_i,
  input  logic [XLEN-1:0] trap_pc_i,
  input  logic            mret_i,
  input  logic            instret_i,
  output logic [XLEN-1:0] mtvec_o,
  output logic [XLEN-1:0] mepc_o,
  output logic            mie_o
);

  localparam logic [11:0] A_MSTATUS  = 12'h300;
  localparam logic [11:0] A_MISA     = 12'h301;
  localparam logic [11:0] A_MTVEC    = 12'h305;
  localparam logic [11:0] A_MSCRATCH = 12'h340;
  localparam logic [11:0] A_MEPC     = 12'h341;
  localparam logic [11:0] A_MCAUSE   = 12'h342;
  localparam logic [11:0] A_MCYCLE   = 12'hB00;
  localparam logic [11:0] A_MINSTRET = 12'hB02;
  localparam logic [11:0] A_MHARTID  = 12'hF14;

  logic            mie_q, mie_d, mpie_q, mpie_d;
  logic [XLEN-1:0] mtvec_q, mtvec_d, mepc_q, mepc_d, mcause_q, mcause_d;
  logic [XLEN-1:0] mscratch_q, mscratch_d, mcycle_q, mcycle_d, minstret_q, minstret_d;

  // Only MIE/MPIE are stored; MPP is wired to M-mode.
  function automatic logic [XLEN-1:0] mstatus_view(input logic mie, input logic mpie);
    return {{(XLEN-13){1'b0}}, 2'b11, 3'b000, mpie, 3'b000, mie, 3'b000};
  endfunction

  logic wr_mstatus, wr_mtvec, wr_mscratch, wr_mepc, wr_mcause, wr_mcycle, wr_minstret;
  assign wr_mstatus  = csr_wen_i && (csr_waddr_i == A_MSTATUS);
  assign wr_mtvec    = csr_wen_i && (csr_waddr_i == A_MTVEC);
  assign wr_mscratch = csr_wen_i && (csr_waddr_i == A_MSCRATCH);
  assign wr_mepc     = csr_wen_i && (csr_waddr_i == A_MEPC);
  assign wr_mcause   = csr_wen_i && (csr_waddr_i == A_MCAUSE);
  assign wr_mcycle   = csr_wen_i && (csr_waddr_i == A_MCYCLE);
  assign wr_minstret = csr_wen_i && (csr_waddr_i == A_MINSTRET);

  always_comb begin
    mie_d      = mie_q;
    mpie_d     = mpie_q;
    mtvec_d    = mtvec_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    mscratch_d = mscratch_q;
    mcycle_d   = mcycle_q + 1'b1;
    minstret_d = minstret_q + XLEN'(instret_i);

    // trap > mret > CSR write, but only for the trap-owned state
    if (trap_valid_i) begin
      mepc_d   = {trap_pc_i[XLEN-1:2], 2'b00};
      mcause_d = trap_cause_i;
      mpie_d   = mie_q;
      mie_d    = 1'b0;
    end else if (mret_i) begin
      mie_d  = mpie_q;
      mpie_d = 1'b1;
    end else begin
      if (wr_mstatus) begin
        mie_d  = csr_wdata_i[3];
        mpie_d = csr_wdata_i[7];
      end
      if (wr_mepc)   mepc_d   = {csr_wdata_i[XLEN-1:2], 2'b00};
      if (wr_mcause) mcause_d = csr_wdata_i;
    end

    if (wr_mtvec)    mtvec_d    = {csr_wdata_i[XLEN-1:2], 2'b00};
    if (wr_mscratch) mscratch_d = csr_wdata_i;
    if (wr_mcycle)   mcycle_d   = csr_wdata_i;
    if (wr_minstret) minstret_d = csr_wdata_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mie_q      <= 1'b0;
      mpie_q     <= 1'b0;
      mtvec_q    <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mscratch_q <= '0;
      mcycle_q   <= '0;
      minstret_q <= '0;
    end else begin
      mie_q      <= mie_d;
      mpie_q     <= mpie_d;
      mtvec_q    <= mtvec_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mscratch_q <= mscratch_d;
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
    end
  end

`ifdef CSR_BYPASS_EN
  logic            byp_ok;
  logic [XLEN-1:0] byp_data;
  always_comb begin
    byp_ok   = 1'b1;
    byp_data = csr_wdata_i;
    case (csr_waddr_i)
      A_MSTATUS:             byp_data = mstatus_view(csr_wdata_i[3], csr_wdata_i[7]);
      A_MTVEC, A_MEPC:       byp_data = {csr_wdata_i[XLEN-1:2], 2'b00};
      A_MSCRATCH, A_MCAUSE,
      A_MCYCLE, A_MINSTRET:  byp_data = csr_wdata_i;
      default:               byp_ok   = 1'b0;
    endcase
  end
`endif

  always_comb begin
    csr_rdata_o   = '0;
    csr_illegal_o = 1'b0;
    case (csr_raddr_i)
      A_MSTATUS:  csr_rdata_o = mstatus_view(mie_q, mpie_q);
      A_MISA:     csr_rdata_o = MISA_VAL;
      A_MTVEC:    csr_rdata_o = mtvec_q;
      A_MSCRATCH: csr_rdata_o = mscratch_q;
      A_MEPC:     csr_rdata_o = mepc_q;
      A_MCAUSE:   csr_rdata_o = mcause_q;
      A_MCYCLE:   csr_rdata_o = mcycle_q;
      A_MINSTRET: csr_rdata_o = minstret_q;
      A_MHARTID:  csr_rdata_o = HART_ID;
      default:    csr_illegal_o = 1'b1;
    endcase
`ifdef CSR_BYPASS_EN
    if (csr_wen_i && byp_ok && (csr_waddr_i == csr_raddr_i)) csr_rdata_o = byp_data;
`endif
  end

  assign mtvec_o = mtvec_q;
  assign mepc_o  = mepc_q;
  assign mie_o   = mie_q;

endmodule
